// File: rtl/snd_pkg.sv
// Shared constants for the sound mailbox: register map, status and control bit positions.
package snd_pkg;

   localparam int unsigned DATA_W = 8;

   // Audio-side register addresses
   localparam logic [1:0] ADDR_FIFO   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_REPLY  = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   // Audio status register bit positions; count occupies [3:0]
   localparam int unsigned ST_FULL   = 7;
   localparam int unsigned ST_EMPTY  = 6;
   localparam int unsigned ST_OVF    = 5;
   localparam int unsigned ST_RVALID = 4;
   localparam int unsigned ST_CNT_W  = 4;

   // Main-side status bit positions; [4:0] read as zero
   localparam int unsigned MS_RVALID = 7;
   localparam int unsigned MS_FULL   = 6;
   localparam int unsigned MS_OVF    = 5;

   // Control register bit positions
   localparam int unsigned CTRL_OVF_CLR = 0;
   localparam int unsigned CTRL_FLUSH   = 1;
   localparam int unsigned CTRL_IRQ_EN  = 2;

endpackage

// File: rtl/snd_cmd_fifo.sv
// Command FIFO from the main CPU to the audio CPU: storage, wrapping pointers and occupancy.
module snd_cmd_fifo
   import snd_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_o,
   output logic [CW-1:0]     count_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a push into a full FIFO is legal alongside it
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   // Next pointers and occupancy; flush dominates any same-cycle push or pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; stale contents are unreachable once the pointers clear
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/snd_mailbox_ctrl.sv
// Main/audio CPU mailbox: command FIFO towards audio, reply latch back, status and audio IRQ.
module snd_mailbox_ctrl
   import snd_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic              audio_clk,
   input  logic              RESET_n,
   input  logic              m_wr,
   input  logic [DATA_W-1:0] m_din,
   input  logic              m_rd,
   output logic [DATA_W-1:0] m_dout,
   output logic [DATA_W-1:0] m_status,
   input  logic              a_en,
   input  logic              a_cs,
   input  logic              a_rw_n,
   input  logic [1:0]        a_addr,
   input  logic [DATA_W-1:0] a_din,
   output logic [DATA_W-1:0] a_dout,
   output logic              a_irq
);

   logic [DATA_W-1:0] fifo_dout;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;

   logic              a_acc_c, pop_c, push_c, flush_c;
   logic              reply_wr_c, ctrl_wr_c, ovf_set_c, ovf_clr_c;

   logic              ovf_q, ovf_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] reply_q, reply_d;
   logic              irq_en_q, irq_en_d;
   logic              irq_q, irq_d;

   // Audio access decode; only cycles with the CPU clock enable and chip select count
   assign a_acc_c    = a_en & a_cs;
   assign pop_c      = a_acc_c &  a_rw_n & (a_addr == ADDR_FIFO) & ~fifo_empty;
   assign reply_wr_c = a_acc_c & ~a_rw_n & (a_addr == ADDR_REPLY);
   assign ctrl_wr_c  = a_acc_c & ~a_rw_n & (a_addr == ADDR_CTRL);
   assign flush_c    = ctrl_wr_c & a_din[CTRL_FLUSH];
   assign ovf_clr_c  = ctrl_wr_c & a_din[CTRL_OVF_CLR];

   // A flushed push is discarded silently; a full push beside a pop is accepted
   assign push_c     = m_wr & (~fifo_full | pop_c) & ~flush_c;
   assign ovf_set_c  = m_wr & fifo_full & ~pop_c & ~flush_c;

   snd_cmd_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk_i   (audio_clk),
      .rst_ni  (RESET_n),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .flush_i (flush_c),
      .din_i   (m_din),
      .dout_o  (fifo_dout),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next state for overflow, reply handshake, IRQ enable and IRQ output
   always_comb begin
      ovf_d    = ovf_q;
      rvalid_d = rvalid_q;
      reply_d  = reply_q;
      irq_en_d = irq_en_q;
      irq_d    = irq_en_q & ~fifo_empty;
      if (ovf_clr_c) ovf_d = 1'b0;
      if (ovf_set_c) ovf_d = 1'b1;
      if (m_rd)      rvalid_d = 1'b0;
      if (reply_wr_c) begin
         reply_d  = a_din;
         rvalid_d = 1'b1;
      end
      if (ctrl_wr_c) irq_en_d = a_din[CTRL_IRQ_EN];
   end

   // Control and reply registers
   always_ff @(posedge audio_clk or negedge RESET_n) begin
      if (!RESET_n) begin
         ovf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         reply_q  <= '0;
         irq_en_q <= 1'b1;
         irq_q    <= 1'b0;
      end else begin
         ovf_q    <= ovf_d;
         rvalid_q <= rvalid_d;
         reply_q  <= reply_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign m_dout = reply_q;
   assign a_irq  = irq_q;

   // Main-side status view
   always_comb begin
      m_status            = '0;
      m_status[MS_RVALID] = rvalid_q;
      m_status[MS_FULL]   = fifo_full;
      m_status[MS_OVF]    = ovf_q;
   end

   // Audio read mux; an empty FIFO reads as zero, unmapped reads as zero
   always_comb begin
      a_dout = '0;
      if (a_cs && a_rw_n) begin
         case (a_addr)
            ADDR_FIFO: a_dout = fifo_empty ? '0 : fifo_dout;
            ADDR_STATUS: begin
               a_dout[ST_CNT_W-1:0] = ST_CNT_W'(fifo_count);
               a_dout[ST_FULL]      = fifo_full;
               a_dout[ST_EMPTY]     = fifo_empty;
               a_dout[ST_OVF]       = ovf_q;
               a_dout[ST_RVALID]    = rvalid_q;
            end
            default: a_dout = '0;
         endcase
      end
   end

endmodule

// File: doc/snd_mailbox_ctrl.md
SND_MAILBOX_CTRL -- requirements
Module: snd_mailbox_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, meaning the occupancy count width.
REQ-003 SHALL have port audio_clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port RESET_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port m_wr, input, 1, a main-CPU command write strobe, one audio_clk wide.
REQ-006 SHALL have port m_din, input, 8, the command byte.
REQ-007 SHALL have port m_rd, input, 1, a main-CPU reply read strobe, one audio_clk wide.
REQ-008 SHALL have port m_dout, output, 8, the reply latch.
REQ-009 SHALL have port m_status, output, 8, the main-side status: {reply_valid, full, overflow, 5'b0}.
REQ-010 SHALL have port a_en, input, 1, the audio CPU clock enable (auPH0).
REQ-011 SHALL have port a_cs, input, 1, the audio CPU chip select, active-high.
REQ-012 SHALL have port a_rw_n, input, 1, the audio CPU read (1) or write (0) select.
REQ-013 SHALL have port a_addr, input, 2, the register select.
REQ-014 SHALL have port a_din, input, 8, the audio CPU write data.
REQ-015 SHALL have port a_dout, output, 8, the audio CPU read data.
REQ-016 SHALL have port a_irq, output, 1, the audio CPU interrupt, active-high and level.

Function
REQ-017 An audio access SHALL occur only in a cycle where a_en & a_cs are both high; a_dout SHALL be combinational from the current state.
REQ-018 The audio register map SHALL be:
- 0 read: FIFO head; the access pops one entry.
- 1 read: status {full, empty, overflow, reply_valid, count[3:0]}, with count zero-extended or truncated to 4 bits.
- 2 write: reply latch; sets reply_valid.
- 3 write: control; bit0=1 clears overflow, bit1=1 flushes the FIFO, bit2 sets irq_en.
- Writes to 0 or 1 and reads of 2 or 3 SHALL be ignored; those reads return 8'h00.
REQ-019 m_wr with the FIFO not full SHALL store m_din at the tail at the clock edge; it is readable by the audio CPU on the next cycle.
REQ-020 m_wr with the FIFO full and no pop in the same cycle SHALL drop the byte and set overflow; the FIFO contents SHALL be unchanged.
REQ-021 A push and a pop in the same cycle SHALL both take effect; count is unchanged, including when the FIFO is full; overflow SHALL NOT be set.
REQ-022 A pop from an empty FIFO SHALL return 8'h00 and leave all state unchanged.
REQ-023 A flush SHALL win over a same-cycle push or pop: count becomes 0, pointers reset, and the pushed byte is discarded without setting overflow.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH; full = (count==DEPTH) and empty = (count==0).
REQ-025 a_irq SHALL equal irq_en & !empty, registered, so it asserts 1 cycle after the push edge and deasserts 1 cycle after the pop that empties the FIFO.
REQ-026 m_rd SHALL clear reply_valid; when an audio reply write occurs in the same cycle, the write SHALL win and reply_valid SHALL be 1.
REQ-027 m_dout SHALL hold the last reply written, independent of m_rd.
REQ-028 Overflow SHALL be sticky until a control write with bit0=1; when a new overflow event occurs in the same cycle as the clear, overflow SHALL remain set.

Reset
REQ-029 On RESET_n low, immediately:
- count, pointers, overflow, reply_valid and the reply latch SHALL be 0.
- a_irq SHALL be 0.
- irq_en SHALL be 1.
- m_status SHALL be 8'h00.
- FIFO storage need not be cleared.
REQ-030 Reset deasserting mid-transfer SHALL discard all pending commands; the first m_wr after release SHALL be stored at slot 0.

Structure
REQ-031 Register addresses, status bit positions and control bit positions SHALL be localparams in the shared package snd_pkg.
REQ-032 FIFO storage and pointers SHALL be one sub-module, snd_cmd_fifo, with push, pop, flush, dout, count, full and empty; all register decode and the reply and IRQ logic SHALL live in the top level.

Verification
REQ-033 Reset, then m_wr 8'h12 -> a_irq=1 after 2 edges; audio read of addr 0 returns 12 -> a_irq=0 one cycle after the pop.
REQ-034 Five m_wr (01..05) with DEPTH=4 -> status reads full=1, overflow=1, count=4; pops return 01,02,03,04, then a fifth pop returns 00.
REQ-035 With the FIFO full, m_wr 8'hAA in the same cycle as a pop -> pop returns the old head, count stays 4, overflow=0, and AA is the last entry.
REQ-036 Three pushes, then a control write 8'h02 in the same cycle as m_wr 8'h55 -> count=0, empty=1, a_irq=0.
REQ-037 An audio write of 8'h7E to addr 2 in the same cycle as m_rd -> m_dout=7E and m_status[7]=1; a later m_rd alone -> m_status[7]=0.
REQ-038 RESET_n pulsed low for 3 cycles with 2 entries queued -> all outputs 0 during reset; after release, m_wr 8'h33 then a pop returns 33.
